// File: rtl/pio_clkdiv_multi.sv
// ---------------------------------------------------------------------------
// pio_clkdiv_multi
//
// Bank of independent fractional clock-enable dividers, one per PIO state
// machine. Each channel turns the system clock into a stream of single-cycle
// enable pulses whose long-run rate is exactly ONE/D per enabled cycle, where
// D is an unsigned INT_W.FRAC_W fixed-point divisor. A fractional divisor
// makes the pulse spacing alternate between floor(D) and ceil(D) cycles.
//
// Ports
//   clk      in   1                      clock, rising-edge
//   reset    in   1                      synchronous, active-high reset
//   en       in   NUM_CH                 per-channel run enable
//   restart  in   NUM_CH                 per-channel phase restart
//   div      in   NUM_CH*(INT_W+FRAC_W)  packed divisors, channel n at
//                                        [n*(INT_W+FRAC_W) +: INT_W+FRAC_W]
//   penable  out  NUM_CH                 registered single-cycle pulses
//
// Divisor encoding per channel
//   integer part 0      -> D = 2^INT_W (fraction ignored)
//   integer part 1      -> fast mode, penable follows en every cycle
//   integer part >= 2   -> fractional divide mode
// ---------------------------------------------------------------------------
module pio_clkdiv_multi #(
  parameter int NUM_CH = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH-1:0]                 en,
  input  logic [NUM_CH-1:0]                 restart,
  input  logic [NUM_CH*(INT_W+FRAC_W)-1:0]  div,
  output logic [NUM_CH-1:0]                 penable
);

  localparam int DIV_W = INT_W + FRAC_W;
  // One extra bit so that D = 2^INT_W (the integer-part-zero case) fits.
  localparam int ACC_W = DIV_W + 1;

  localparam logic [ACC_W-1:0] ONE   = ACC_W'(1) << FRAC_W;
  localparam logic [ACC_W-1:0] D_MAX = ACC_W'(1) << DIV_W;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] div_w;
    logic [INT_W-1:0] int_part;
    logic [ACC_W-1:0] d_eff;
    logic [ACC_W-1:0] acc_inc;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             pen_q, pen_d;

    assign div_w    = div[g*DIV_W +: DIV_W];
    assign int_part = div_w[DIV_W-1:FRAC_W];
    assign d_eff    = (int_part == '0) ? D_MAX : {1'b0, div_w};
    // acc_q is always below D_MAX, so acc_q + ONE cannot overflow ACC_W.
    assign acc_inc  = acc_q + ONE;

    // NOTE: every output of this block gets a default first, so no path
    // leaves acc_d/pen_d unassigned and no latch is inferred.
    always_comb begin
      acc_d = acc_q;
      pen_d = 1'b0;
      if (restart[g]) begin
        acc_d = '0;
      end else if (int_part == INT_W'(1)) begin
        // Fast mode: every enabled cycle is a pulse; phase is meaningless.
        acc_d = '0;
        pen_d = en[g];
      end else if (en[g]) begin
        if (acc_q >= d_eff) begin
          // Divisor shrank below the held phase: fire once and restart the
          // phase rather than wrapping through a huge modular interval.
          acc_d = '0;
          pen_d = 1'b1;
        end else if (acc_inc < d_eff) begin
          acc_d = acc_inc;
        end else begin
          // Keep the remainder so fractional error never accumulates.
          acc_d = acc_inc - d_eff;
          pen_d = 1'b1;
        end
      end
    end

    // NOTE: state registers use non-blocking assignments so every channel
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q <= '0;
        pen_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        pen_q <= pen_d;
      end
    end

    assign penable[g] = pen_q;
  end

endmodule

// File: tb/tb_pio_clkdiv_multi.sv
// ---------------------------------------------------------------------------
// tb_pio_clkdiv_multi
//
// Directed bench for pio_clkdiv_multi (default parameters). A fixed-point
// phase model predicts every penable bit each cycle; directed scenarios add
// hand-computed pulse positions and counts that pin the model itself.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pio_clkdiv_multi;

  localparam int NCH = 4;
  localparam int IW  = 16;
  localparam int FW  = 8;
  localparam int DW  = IW + FW;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    restart;
  logic [NCH*DW-1:0] div;
  logic [NCH-1:0]    penable;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pio_clkdiv_multi #(.NUM_CH(NCH), .INT_W(IW), .FRAC_W(FW)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (restart),
    .div     (div),
    .penable (penable)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_div(input int ch, input logic [DW-1:0] v);
    div[ch*DW +: DW] = v;
  endtask

  // ---------------- behavioural model ----------------
  // Phase is a plain integer in units of 1/256 cycle; a pulse is due each
  // time the phase has advanced by a whole divisor.
  longint         ph [NCH];
  logic [NCH-1:0] exp_pen = '0;
  bit             model_live = 1'b0;

  initial for (int n = 0; n < NCH; n++) ph[n] = 0;

  always @(posedge clk) begin
    longint d, p, ip;
    logic   pulse;
    for (int n = 0; n < NCH; n++) begin
      ip    = longint'(div[n*DW +: DW]) / 256;
      d     = (ip == 0) ? 65536 * 256 : longint'(div[n*DW +: DW]);
      p     = ph[n];
      pulse = 1'b0;
      if (reset || restart[n]) begin
        p = 0;
      end else if (ip == 1) begin
        p     = 0;
        pulse = en[n];
      end else if (en[n]) begin
        if (p >= d) begin
          p     = 0;
          pulse = 1'b1;
        end else begin
          p = p + 256;
          if (p >= d) begin
            p     = p - d;
            pulse = 1'b1;
          end
        end
      end
      ph[n]      <= p;
      exp_pen[n] <= pulse;
    end
    model_live <= 1'b1;
  end

  always @(negedge clk)
    if (model_live) check("penable_vs_model", penable, exp_pen);

  // ---------------- directed stimulus ----------------
  int cnt, first, mism, mism_before, mask;
  int t [4];

  initial begin
    reset   = 1'b1;
    en      = '1;
    restart = '0;
    div     = '0;
    for (int n = 0; n < NCH; n++) set_div(n, 24'h000100);
    repeat (3) tick();
    check("reset_penable_zero", penable, 0);
    en = '0;
    for (int n = 0; n < NCH; n++) set_div(n, 24'h000000);
    tick();
    reset = 1'b0;
    tick();

    // Fast mode 1.0 on ch0.
    set_div(0, 24'h000100);
    en[0] = 1'b1;
    tick();
    check("fast_first_edge", penable[0], 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); cnt += int'(penable[0]); end
    check("fast_every_cycle", cnt, 5);
    en[0] = 1'b0;
    tick();
    check("fast_en_low", penable[0], 0);

    // Divide by 4.0 on ch0.
    set_div(0, 24'h000400);
    en[0] = 1'b1;
    cnt = 0; first = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (penable[0]) begin cnt++; if (first == 0) first = i; end
    end
    check("div4_first_pulse", first, 4);
    check("div4_pulses_100", cnt, 25);
    en[0] = 1'b0;

    // Divide by 2.5 on ch1 from restart.
    set_div(1, 24'h000280);
    en[1] = 1'b1;
    restart[1] = 1'b1;
    tick();
    check("restart_no_pulse", penable[1], 0);
    restart[1] = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (penable[1]) begin if (cnt < 4) t[cnt] = i; cnt++; end
    end
    check("div2p5_interval0", t[0], 3);
    check("div2p5_interval1", t[1] - t[0], 2);
    check("div2p5_interval2", t[2] - t[1], 3);
    check("div2p5_interval3", t[3] - t[2], 2);
    check("div2p5_pulses_100", cnt, 40);

    // Phase alignment of ch0 and ch2 at 3.0; ch1 keeps running.
    set_div(0, 24'h000300);
    set_div(2, 24'h000300);
    en[0] = 1'b1;
    tick();
    en[2] = 1'b1;
    mism_before = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (penable[0] != penable[2]) mism_before++;
    end
    check("ch0_ch2_offset_before", int'(mism_before > 0), 1);
    restart = 4'b0101;
    tick();
    check("align_restart_quiet", {penable[2], penable[0]}, 0);
    restart = '0;
    mism = 0; cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (penable[0] != penable[2]) mism++;
      cnt += int'(penable[0]);
    end
    check("ch0_ch2_aligned", mism, 0);
    check("aligned_pulses_30", cnt, 10);
    en[2] = 1'b0;

    // Stale phase: 8.0 with phase 6.0, then divisor drops to 3.0.
    set_div(0, 24'h000800);
    restart[0] = 1'b1;
    tick();
    restart[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); cnt += int'(penable[0]); end
    check("div8_no_pulse_6", cnt, 0);
    set_div(0, 24'h000300);
    tick();
    check("stale_pulse_next_edge", penable[0], 1);
    mask = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (penable[0]) mask |= (1 << i);
    end
    check("after_stale_every3", mask, (1 << 3) | (1 << 6));

    // Reset mid-count at 8.0.
    set_div(0, 24'h000800);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midrun_reset_zero", penable, 0);
    reset = 1'b0;
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (penable[0] && first == 0) first = i;
    end
    check("post_reset_first_pulse", first, 8);

    // Integer part 0 -> 65536 cycles (fraction 0x80 must be ignored);
    // a 10-cycle enable gap delays the pulse by 10 cycles.
    en = '0;
    set_div(3, 24'h000080);
    en[3] = 1'b1;
    restart[3] = 1'b1;
    tick();
    restart[3] = 1'b0;
    cnt = 0; first = 0;
    for (int i = 1; i <= 65550; i++) begin
      tick();
      if (penable[3]) begin cnt++; if (first == 0) first = i; end
      if (i == 30000) en[3] = 1'b0;
      if (i == 30010) en[3] = 1'b1;
    end
    check("div65536_pulse_pos", first, 65546);
    check("div65536_pulse_cnt", cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pio_clkdiv_multi.md
PIO_CLKDIV_MULTI -- requirements
Module: pio_clkdiv_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels (one per state machine).
REQ-002 Parameter INT_W, default 16: integer bits of each divisor.
REQ-003 Parameter FRAC_W, default 8: fractional bits of each divisor.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  NUM_CH  per-channel run enable.
REQ-007 restart  input  NUM_CH  per-channel phase-restart pulse.
REQ-008 div  input  NUM_CH*(INT_W+FRAC_W)  packed unsigned fixed-point divisors; channel n occupies bits [n*(INT_W+FRAC_W) +: INT_W+FRAC_W], integer part in the upper INT_W bits.
REQ-009 penable  output  NUM_CH  per-channel registered single-cycle enable pulses.

Function
REQ-010 Let ONE = 1<<FRAC_W; the effective divisor D equals div[n], except integer part 0, which means D = 2^INT_W (fraction ignored).
REQ-011 Each channel holds an accumulator acc of INT_W+FRAC_W+1 bits, wide enough to hold D with no truncation.
REQ-012 div is sampled every cycle; no load strobe; a divisor change takes effect on the next edge.
REQ-013 Fast mode (integer part == 1, i.e. 1.0 <= D < 2.0): penable[n] <= en[n] every cycle; acc <= 0.
REQ-014 Divide mode, en=1, acc+ONE < D: acc <= acc+ONE; penable <= 0.
REQ-015 Divide mode, en=1, D <= acc+ONE <= acc+D: acc <= acc+ONE-D; penable <= 1.
REQ-016 Divide mode, stale phase (acc >= D after a divisor decrease): acc <= 0; penable <= 1; no more than one pulse per stale event.
REQ-017 Long-run pulse rate in divide mode is exactly ONE/D per enabled cycle, with no accumulated error; pulse intervals are floor(D) or ceil(D) cycles.
REQ-018 en[n]=0: acc holds its value; penable[n] <= 0; on re-enable, counting resumes from the held phase.
REQ-019 restart[n]=1: acc <= 0, penable[n] <= 0 that cycle; restart overrides en and mode; the channel counts from zero on the next enabled edge.
REQ-020 Asserting several restart bits in one cycle phase-aligns those channels exactly: equal D and en give identical penable streams afterwards.
REQ-021 Channels are fully independent; no input of channel m affects channel n (m != n).
REQ-022 Latency: a pulse decision made at edge k is visible on penable during cycle k+1 (one register stage, no combinational path from inputs to penable).

Reset
REQ-023 While reset=1: all acc <= 0 and all penable <= 0, overriding en and restart.
REQ-024 Reset asserted mid-operation discards all phase; after release every channel behaves as freshly restarted.

Verification
REQ-025 Ch0 div=0x000100 (1.0), en=1 after reset -> penable[0]=1 every cycle from the first edge after en; en=0 -> 0 the next cycle.
REQ-026 Ch0 div=0x000400 (4.0), en=1 -> first pulse after the 4th enabled edge, then every 4 cycles; 25 pulses in 100 cycles.
REQ-027 Ch1 div=0x000280 (2.5) from restart -> pulse intervals 3,2,3,2,...; 40 pulses in 100 cycles.
REQ-028 Ch0 and ch2 both div=3.0, ch2 started 1 cycle later; restart=4'b0101 -> identical penable[0]/penable[2] from then on; ch1 and ch3 unaffected.
REQ-029 Ch3 div=0x000000 -> exactly one pulse per 65536 enabled cycles; en low for 10 cycles mid-count delays the pulse by exactly 10 cycles.
REQ-030 Ch0 div=8.0 with acc=6.0, div changed to 3.0 -> pulse next edge, acc=0, then every 3 cycles; reset mid-count -> all penable 0, first pulse 8 enabled cycles after release.
